// File: rtl/lif_seq_pkg.sv
// Shared types and widths for the LIF timestep sequencer.
package lif_seq_pkg;

  localparam int STEP_W_DEF = 16;
  localparam int CNTL_W_DEF = 3;
  localparam int STAT_W     = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    PAUSE = 3'b010,
    RESET = 3'b011
  } cntl_code_t;

  // State literals carry a prefix so they do not collide with the code names.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SWEEP,
    ST_ADV,
    ST_STEP_END,
    ST_FIN
  } seq_state_t;

endpackage

// File: rtl/lif_seq_stat_cnt.sv
// Saturating statistics counter; clear restarts the count, counting the
// current cycle when enable is also high.
module lif_seq_stat_cnt
  import lif_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [STAT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= {{(STAT_W-1){1'b0}}, en_i};
    end else if (en_i && !(&cnt_o)) begin
      cnt_o <= cnt_o + STAT_W'(1);
    end
  end

endmodule

// File: rtl/lif_step_sequencer.sv
// Timestep sequencer driving the presyn/postsyn counter control codes of one
// LIF timestep per step. Optional statistics ports under LIF_SEQ_STATS_EN.
module lif_step_sequencer
  import lif_seq_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int CNTL_W = CNTL_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STEP_W-1:0] num_steps_i,
  input  logic              presyn_done_i,
  input  logic              postsyn_done_i,
  input  logic              fifo_afull_i,
  output logic [CNTL_W-1:0] presyn_cntl_sig,
  output logic [CNTL_W-1:0] postsyn_cntl_sig,
  output logic              busy_o,
  output logic              step_done_o,
  output logic              run_done_o,
  output logic [STEP_W-1:0] step_cnt_o
`ifdef LIF_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt_o,
  output logic [STAT_W-1:0] step_cyc_o
`endif
);

  seq_state_t        state_q, state_d;
  cntl_code_t        pre_q, pre_d, post_q, post_d;
  logic              abort_pend_q, abort_d;
  logic              busy_q, step_done_q, run_done_q;
  logic [STEP_W-1:0] steps_q, step_cnt_q;
  logic              start_acc;

  // start_i is a one-cycle request with no ready: it is taken only in IDLE.
  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign abort_d   = (state_q != ST_IDLE) && abort_i;

  always_comb begin
    state_d = state_q;
    if (abort_d) begin
      state_d = ST_CLR;
    end else begin
      case (state_q)
        ST_IDLE:     if (start_i) state_d = (num_steps_i != '0) ? ST_CLR : ST_FIN;
        ST_CLR:      state_d = abort_pend_q ? ST_IDLE : ST_SWEEP;
        ST_SWEEP: begin
          // A done seen while paused, or while pause is being requested, waits.
          if (presyn_done_i && !fifo_afull_i && (pre_q != PAUSE))
            state_d = postsyn_done_i ? ST_STEP_END : ST_ADV;
        end
        ST_ADV:      state_d = ST_SWEEP;
        ST_STEP_END: state_d = (step_cnt_q == steps_q) ? ST_FIN : ST_SWEEP;
        ST_FIN:      state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pre_d  = IDLE;
    post_d = IDLE;
    case (state_d)
      ST_CLR:      begin pre_d = RESET; post_d = RESET; end
      ST_SWEEP:    pre_d = fifo_afull_i ? PAUSE : START;
      ST_ADV:      begin pre_d = RESET; post_d = START; end
      ST_STEP_END: begin pre_d = RESET; post_d = RESET; end
      default:     begin pre_d = IDLE; post_d = IDLE; end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      pre_q        <= IDLE;
      post_q       <= IDLE;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      step_done_q  <= 1'b0;
      run_done_q   <= 1'b0;
      steps_q      <= '0;
      step_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      abort_pend_q <= abort_d;
      busy_q       <= (state_d != ST_IDLE);
      step_done_q  <= (state_d == ST_STEP_END);
      run_done_q   <= (state_d == ST_FIN);
      if (start_acc) steps_q <= num_steps_i;
      if (start_acc) step_cnt_q <= '0;
      else if (state_d == ST_STEP_END) step_cnt_q <= step_cnt_q + STEP_W'(1);
    end
  end

  assign presyn_cntl_sig  = CNTL_W'(pre_q);
  assign postsyn_cntl_sig = CNTL_W'(post_q);
  assign busy_o           = busy_q;
  assign step_done_o      = step_done_q;
  assign run_done_o       = run_done_q;
  assign step_cnt_o       = step_cnt_q;

`ifdef LIF_SEQ_STATS_EN
  logic              stall_en, run_clr, run_en;
  logic [STAT_W-1:0] run_cyc, step_cyc_q;

  assign stall_en = (state_q == ST_SWEEP) && (pre_q == PAUSE);
  assign run_clr  = start_acc || (state_q == ST_STEP_END);
  assign run_en   = (state_q != ST_IDLE);

  lif_seq_stat_cnt u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (start_acc),
    .en_i  (stall_en),
    .cnt_o (stall_cnt_o)
  );

  // Running length of the current step; the STEP_END cycle opens the next one.
  lif_seq_stat_cnt u_run_cyc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (run_clr),
    .en_i  (run_en),
    .cnt_o (run_cyc)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      step_cyc_q <= '0;
    end else if (start_acc) begin
      step_cyc_q <= '0;
    end else if (state_q == ST_STEP_END) begin
      step_cyc_q <= (&run_cyc) ? run_cyc : run_cyc + STAT_W'(1);
    end
  end

  assign step_cyc_o = step_cyc_q;
`endif

endmodule

// File: tb/tb_lif_step_sequencer.sv
// Bench for lif_step_sequencer with 4-entry presyn / 2-group postsyn counter
// models; statistics ports are checked when LIF_SEQ_STATS_EN is defined.
module tb_lif_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        fifo_afull = 1'b0;
  logic [15:0] num_steps = '0;
  logic        presyn_done, postsyn_done;
  logic [2:0]  pre, post;
  logic        busy, step_done, run_done;
  logic [15:0] step_cnt;
`ifdef LIF_SEQ_STATS_EN
  logic [31:0] stall_cnt, step_cyc;
`endif

  logic [1:0]  pre_cnt;
  logic        grp;

  int n_checks = 0;
  int n_fail   = 0;

  int          sd_edges[$];
  int          sd_posts[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          rd_edge, rd_n, pause_n;

  lif_step_sequencer dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .start_i          (start),
    .abort_i          (abort),
    .num_steps_i      (num_steps),
    .presyn_done_i    (presyn_done),
    .postsyn_done_i   (postsyn_done),
    .fifo_afull_i     (fifo_afull),
    .presyn_cntl_sig  (pre),
    .postsyn_cntl_sig (post),
    .busy_o           (busy),
    .step_done_o      (step_done),
    .run_done_o       (run_done),
    .step_cnt_o       (step_cnt)
`ifdef LIF_SEQ_STATS_EN
    ,
    .stall_cnt_o      (stall_cnt),
    .step_cyc_o       (step_cyc)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Presyn counter (0..3, holds at terminal) and postsyn group counter (0..1)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 2'd0;
      grp     <= 1'b0;
    end else begin
      if (pre == 3'b011) pre_cnt <= 2'd0;
      else if (pre == 3'b001 && pre_cnt != 2'd3) pre_cnt <= pre_cnt + 2'd1;
      if (post == 3'b011) grp <= 1'b0;
      else if (post == 3'b001) grp <= 1'b1;
    end
  end

  assign presyn_done  = (pre_cnt == 2'd3);
  assign postsyn_done = grp;

  typedef struct {
    logic        start;
    logic        abort;
    logic [15:0] ns;
    logic [2:0]  pre;
    logic [2:0]  post;
    logic        busy;
    logic        sd;
    logic        rd;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic s, logic a, logic [15:0] n, logic [2:0] p,
                              logic [2:0] q, logic b, logic sd, logic rd, logic [15:0] c);
    vec_t v;
    v.start = s; v.abort = a; v.ns = n; v.pre = p; v.post = q;
    v.busy = b; v.sd = sd; v.rd = rd; v.cnt = c;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: start a run, optionally hold afull over edges af_lo..af_hi, and
  // record step_done/run_done edges (edge 1 samples the start request).
  task automatic run_one(input logic [15:0] ns, input int af_lo, input int af_hi);
    sd_edges.delete();
    sd_posts.delete();
    got_q.delete();
    rd_edge = -1;
    rd_n    = 0;
    pause_n = 0;
    start     = 1'b1;
    num_steps = ns;
    for (int k = 1; k <= 100; k++) begin
      fifo_afull = (k >= af_lo) && (k <= af_hi);
      if (k == 4) begin
        start     = 1'b1;
        num_steps = 16'd5;
      end
      tick;
      start = 1'b0;
      if (step_done) begin
        sd_edges.push_back(k);
        sd_posts.push_back(int'(post));
        got_q.push_back(step_cnt);
      end
      if (pre == 3'b010) pause_n++;
      if (run_done) begin
        rd_n++;
        rd_edge = k;
      end
      if (rd_edge >= 0 && k >= rd_edge + 1) break;
    end
    fifo_afull = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int adv_seen;
    int stray;

    vecs[0]  = mk(1'b1, 1'b0, 16'd1, 3'd3, 3'd3, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 4; i++) vecs[i] = mk(1'b0, 1'b0, 16'd1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    vecs[5]  = mk(1'b0, 1'b0, 16'd1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 6; i <= 9; i++) vecs[i] = mk(1'b0, 1'b0, 16'd1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    vecs[10] = mk(1'b0, 1'b0, 16'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 16'd1);
    vecs[11] = mk(1'b0, 1'b0, 16'd1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'd1);
    vecs[12] = mk(1'b0, 1'b0, 16'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    // start with abort in IDLE and zero steps: straight to FIN, counter cleared
    vecs[13] = mk(1'b1, 1'b1, 16'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'd0);
    vecs[14] = mk(1'b0, 1'b0, 16'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);

    tick;
    tick;
    check("reset state", 64'({pre, post, busy, step_done, run_done, step_cnt}), 64'd0);
    rst_n = 1'b1;

    // One-step run cycle by cycle: CLR, SWEEP x4, ADV, SWEEP x4, STEP_END, FIN
    for (int i = 0; i < 15; i++) begin
      start     = vecs[i].start;
      abort     = vecs[i].abort;
      num_steps = vecs[i].ns;
      tick;
      check($sformatf("vec[%0d] pre/post/busy/sd/rd/cnt", i),
            64'({pre, post, busy, step_done, run_done, step_cnt}),
            64'({vecs[i].pre, vecs[i].post, vecs[i].busy, vecs[i].sd, vecs[i].rd, vecs[i].cnt}));
    end
    start = 1'b0;
    abort = 1'b0;

    // Three steps; later steps span 11 cycles counting both STEP_END cycles,
    // so pulses land 10 edges apart. Mid-run start/num_steps are ignored.
    exp_q = '{16'd1, 16'd2, 16'd3};
    run_one(16'd3, 0, 0);
    check("3step: step_done count", 64'(sd_edges.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("3step: step_done[%0d] edge", i),
            64'((i < sd_edges.size()) ? sd_edges[i] : -1), 64'(11 + 10 * i));
      check($sformatf("3step: step_cnt at pulse %0d", i),
            64'((i < got_q.size()) ? got_q[i] : 16'hffff), 64'(exp_q[i]));
      check($sformatf("3step: post at STEP_END %0d", i),
            64'((i < sd_posts.size()) ? sd_posts[i] : -1), 64'd3);
    end
    check("3step: run_done edge", 64'(rd_edge), 64'd32);
    check("3step: run_done count", 64'(rd_n), 64'd1);
    check("3step: final step_cnt/busy", 64'({step_cnt, busy}), 64'({16'd3, 1'b0}));
`ifdef LIF_SEQ_STATS_EN
    check("3step: step_cyc", 64'(step_cyc), 64'd11);
    check("3step: stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // afull high for 5 edges mid-sweep: 5 pause cycles, step 5 cycles longer
    run_one(16'd1, 4, 8);
    check("stall: pause cycles", 64'(pause_n), 64'd5);
    check("stall: step_done edge", 64'((sd_edges.size() > 0) ? sd_edges[0] : -1), 64'd16);
    check("stall: run_done edge", 64'(rd_edge), 64'd17);
`ifdef LIF_SEQ_STATS_EN
    check("stall: stall_cnt", 64'(stall_cnt), 64'd5);
    check("stall: step_cyc", 64'(step_cyc), 64'd16);
`endif

    // afull rises in the cycle presyn_done is first seen: done deferred 2 edges
    run_one(16'd1, 6, 6);
    check("coincident: pause cycles", 64'(pause_n), 64'd1);
    check("coincident: step_done edge", 64'((sd_edges.size() > 0) ? sd_edges[0] : -1), 64'd13);
    check("coincident: run_done edge", 64'(rd_edge), 64'd14);

    // Abort in the second ADV of a three-step run
    start     = 1'b1;
    num_steps = 16'd3;
    adv_seen  = 0;
    for (int k = 1; k <= 40 && adv_seen < 2; k++) begin
      tick;
      start = 1'b0;
      if (post == 3'b001) adv_seen++;
    end
    check("abort: reached second ADV", 64'(adv_seen), 64'd2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort: clear codes", 64'({pre, post, busy, step_done, run_done}), 64'(9'b011_011_100));
    tick;
    check("abort: back to IDLE", 64'({pre, post, busy, run_done}), 64'd0);
    check("abort: step_cnt held", 64'(step_cnt), 64'd1);
    stray = 0;
    repeat (6) begin
      tick;
      if (run_done || step_done || busy) stray++;
    end
    check("abort: quiet afterwards", 64'(stray), 64'd0);

    // Asynchronous reset in SWEEP, then a clean one-step run
    start     = 1'b1;
    num_steps = 16'd1;
    tick;
    start = 1'b0;
    tick;
    tick;
    check("rst: in SWEEP before reset", 64'({pre, busy}), 64'({3'd1, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst: outputs cleared without edge", 64'({pre, post, busy, step_done, run_done, step_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(16'd1, 0, 0);
    check("rst: step_done edge after reset", 64'((sd_edges.size() > 0) ? sd_edges[0] : -1), 64'd11);
    check("rst: run_done edge after reset", 64'(rd_edge), 64'd12);
    check("rst: step_cnt/busy after run", 64'({step_cnt, busy}), 64'({16'd1, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
